// File: rtl/eth_rx_arb.sv
// Round-robin frame arbiter: merges CH_COUNT AXI-Stream style frame sources onto one
// output, keeping frames whole, aborting stalled frames and counting frames/errors.
//
// state | meaning
// IDLE  | no grant held, pick next requesting channel round-robin
// PASS  | forwarding beats of granted channel, stall timer running
// ABORT | stall limit hit, waiting to emit the error-terminating beat
// DRAIN | discarding remaining beats of the aborted frame up to its tlast
module eth_rx_arb #(
    parameter int CH_COUNT = 4,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1024,
    parameter int CH_W     = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                         p_in_clk,
    input  logic                         p_in_rst_n,
    input  logic [CH_COUNT*DATA_W-1:0]   s_tdata,
    input  logic [CH_COUNT-1:0]          s_tvalid,
    input  logic [CH_COUNT-1:0]          s_tlast,
    input  logic [CH_COUNT-1:0]          s_tuser,
    output logic [CH_COUNT-1:0]          s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    output logic                         m_tuser,
    output logic [CH_W-1:0]              m_tid,
    input  logic                         m_tready,
    input  logic [CH_W-1:0]              stat_sel,
    input  logic                         stat_clr,
    output logic [CNT_W-1:0]             stat_frames,
    output logic [CNT_W-1:0]             stat_errs
);

    localparam int TM_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} state_t;

    state_t            state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   pick;
    logic              pick_found;
    logic [TM_W-1:0]   timer;
    logic [CNT_W-1:0]  frames [CH_COUNT];
    logic [CNT_W-1:0]  errs   [CH_COUNT];

    logic              sel_valid;
    logic              sel_last;
    logic              sel_user;
    logic [DATA_W-1:0] sel_data;
    logic              out_free;
    logic              accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign sel_valid = s_tvalid[grant];
    assign sel_last  = s_tlast[grant];
    assign sel_user  = s_tuser[grant];
    assign sel_data  = s_tdata[int'(grant)*DATA_W +: DATA_W];
    assign out_free  = !m_tvalid || m_tready;
    assign accept    = sel_valid && s_tready[grant];

    // Scan downward so the lowest offset from last_grant+1 wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = CH_COUNT; i >= 1; i--) begin
            if (s_tvalid[(int'(last_grant) + i) % CH_COUNT]) begin
                pick       = CH_W'((int'(last_grant) + i) % CH_COUNT);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (state == PASS)
            s_tready[grant] = out_free;
        else if (state == DRAIN)
            s_tready[grant] = 1'b1;
    end

    always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
        if (!p_in_rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(CH_COUNT - 1);
            timer      <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tuser    <= 1'b0;
            m_tid      <= '0;
            for (int c = 0; c < CH_COUNT; c++) begin
                frames[c] <= '0;
                errs[c]   <= '0;
            end
        end else begin
            // Drained output empties unless a new beat is loaded below.
            if (m_tvalid && m_tready)
                m_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (pick_found) begin
                        grant <= pick;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        m_tdata  <= sel_data;
                        m_tvalid <= 1'b1;
                        m_tlast  <= sel_last;
                        m_tuser  <= sel_user && sel_last;
                        m_tid    <= grant;
                        timer    <= '0;
                        if (sel_last) begin
                            state      <= IDLE;
                            last_grant <= grant;
                        end
                    end else if (!sel_valid && out_free) begin
                        if (timer == TM_W'(TIMEOUT - 1)) begin
                            timer <= '0;
                            state <= ABORT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    if (out_free) begin
                        m_tdata  <= '0;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b1;
                        m_tuser  <= 1'b1;
                        m_tid    <= grant;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept && sel_last) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stat_clr) begin
                for (int c = 0; c < CH_COUNT; c++) begin
                    frames[c] <= '0;
                    errs[c]   <= '0;
                end
            end else if (state == PASS && accept && sel_last) begin
                frames[grant] <= sat_inc(frames[grant]);
                if (sel_user)
                    errs[grant] <= sat_inc(errs[grant]);
            end else if (state == ABORT && out_free) begin
                frames[grant] <= sat_inc(frames[grant]);
                errs[grant]   <= sat_inc(errs[grant]);
            end
        end
    end

    always_comb begin
        stat_frames = '0;
        stat_errs   = '0;
        if (int'(stat_sel) < CH_COUNT) begin
            stat_frames = frames[stat_sel];
            stat_errs   = errs[stat_sel];
        end
    end

endmodule
